// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson decoder/monitor slice.
//   mon_state_t  : monitor FSM states (SEARCH, LOCKED)
//   ERR_CNT_W    : width of the saturating error counter
//   ERR_CNT_MAX  : saturation value of the error counter
package johnson_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } mon_state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder.
// Maps a WIDTH-bit Johnson code to its sequence index 0 .. 2*WIDTH-1 and
// flags any code that is not part of the Johnson sequence.
//   code  : in  WIDTH           code to decode
//   legal : out 1               code is one of the 2*WIDTH Johnson codes
//   idx   : out clog2(2*WIDTH)  decoded index (0 when not legal)
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]               code,
    output logic                           legal,
    output logic [$clog2(2*WIDTH)-1:0]     idx
);

    localparam int NCODES = 2 * WIDTH;
    localparam int IDX_W  = $clog2(2 * WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [NCODES-1:0] hit;

    // One comparator per legal code. Index k <= WIDTH is k ones from the MSB
    // down; index WIDTH+j is j zeros from the MSB down followed by ones.
    genvar gi;
    generate
        for (gi = 0; gi < NCODES; gi++) begin : g_code
            localparam logic [WIDTH-1:0] PAT = (gi <= WIDTH) ? ~(ALL_ONES >> gi)
                                                             : (ALL_ONES >> (gi - WIDTH));
            assign hit[gi] = (code == PAT);
        end
    endgenerate

    // Patterns are mutually exclusive, so at most one hit bit is set.
    always_comb begin
        legal = |hit;
        idx   = '0;
        for (int i = 0; i < NCODES; i++) begin
            if (hit[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/johnson_decoder_monitor.sv
// Johnson counter decoder and sequence monitor.
// Decodes sampled Johnson codes, checks that successive samples step by one
// (mod 2*WIDTH), and locks after LOCK_CNT consecutive good steps.
// Optional feature macro: JOHNSON_ERRCNT_EN enables the saturating error
// counter; without it err_count is tied to zero.
//   clk          : in  1               clock, rising edge
//   clear        : in  1               asynchronous active-high reset
//   code_in      : in  WIDTH           sampled Johnson code
//   code_valid   : in  1               code_in is valid this cycle
//   load_seen    : in  1               counter preset; accept any legal index
//   state_idx    : out clog2(2*WIDTH)  index of last legal sample
//   idx_valid    : out 1               pulse: state_idx updated
//   illegal_code : out 1               pulse: last sample not a Johnson code
//   seq_error    : out 1               pulse: lock lost
//   locked       : out 1               level: monitor is LOCKED
//   err_count    : out 8               saturating count of seq_error pulses
module johnson_decoder_monitor
    import johnson_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic                           clk,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               code_in,
    input  logic                           code_valid,
    input  logic                           load_seen,
    output logic [$clog2(2*WIDTH)-1:0]     state_idx,
    output logic                           idx_valid,
    output logic                           illegal_code,
    output logic                           seq_error,
    output logic                           locked,
    output logic [ERR_CNT_W-1:0]           err_count
);

    localparam int IDX_W = $clog2(2 * WIDTH);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_CNT);

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;

    johnson_decode #(.WIDTH(WIDTH)) u_decode (
        .code  (code_in),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    mon_state_t       state_reg,     state_next;
    logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
    logic             ref_valid_reg, ref_valid_next;
    logic [IDX_W-1:0] state_idx_reg, state_idx_next;
    logic             idx_valid_reg, idx_valid_next;
    logic             illegal_reg,   illegal_next;
    logic             seq_error_reg, seq_error_next;
    logic             locked_reg;

    logic [IDX_W-1:0] expect_idx;
    logic             step_good;
    logic             bad_sample;

    // Expected successor of the reference index, wrapping at 2*WIDTH-1.
    assign expect_idx = (state_idx_reg == IDX_LAST) ? '0 : state_idx_reg + IDX_W'(1);
    assign step_good  = load_seen || (dec_idx == expect_idx);

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        ref_valid_next = ref_valid_reg;
        state_idx_next = state_idx_reg;
        idx_valid_next = 1'b0;
        illegal_next   = 1'b0;
        seq_error_next = 1'b0;
        bad_sample     = 1'b0;

        if (code_valid) begin
            if (!dec_legal) begin
                // Illegal wins over load_seen; the reference index is kept.
                illegal_next = 1'b1;
                bad_sample   = 1'b1;
            end else begin
                idx_valid_next = 1'b1;
                state_idx_next = dec_idx;
                ref_valid_next = 1'b1;
                // The first legal sample only establishes the reference.
                if (ref_valid_reg) begin
                    if (!step_good) begin
                        bad_sample = 1'b1;
                    end else if (state_reg == SEARCH) begin
                        match_cnt_next = match_cnt_reg + CNT_W'(1);
                        if (match_cnt_reg + CNT_W'(1) >= CNT_LOCK) begin
                            state_next = LOCKED;
                        end
                    end
                end
            end

            if (bad_sample) begin
                match_cnt_next = '0;
                if (state_reg == LOCKED) begin
                    state_next     = SEARCH;
                    seq_error_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg     <= SEARCH;
            match_cnt_reg <= '0;
            ref_valid_reg <= 1'b0;
            state_idx_reg <= '0;
            idx_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            seq_error_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            ref_valid_reg <= ref_valid_next;
            state_idx_reg <= state_idx_next;
            idx_valid_reg <= idx_valid_next;
            illegal_reg   <= illegal_next;
            seq_error_reg <= seq_error_next;
            locked_reg    <= (state_next == LOCKED);
        end
    end

`ifdef JOHNSON_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_count_reg;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            err_count_reg <= '0;
        end else if (seq_error_next && (err_count_reg != ERR_CNT_MAX)) begin
            err_count_reg <= err_count_reg + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = '0;
`endif

    assign state_idx    = state_idx_reg;
    assign idx_valid    = idx_valid_reg;
    assign illegal_code = illegal_reg;
    assign seq_error    = seq_error_reg;
    assign locked       = locked_reg;

endmodule

// File: doc/johnson_decoder_monitor.md
JOHNSON_DECODER_MONITOR -- requirements
Module: johnson_decoder_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: Johnson code width; legal codes = 2*WIDTH.
REQ-002 SHALL have parameter LOCK_CNT, default 3: consecutive good samples needed to lock.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port code_in  input  WIDTH  Johnson code sampled from the counter.
REQ-006 SHALL have port code_valid  input  1  code_in is sampled this cycle.
REQ-007 SHALL have port load_seen  input  1  counter was preset this step; skip the step check.
REQ-008 SHALL have port state_idx  output  $clog2(2*WIDTH)  decoded index of the last valid sample.
REQ-009 SHALL have port idx_valid  output  1  one-cycle pulse: state_idx updated.
REQ-010 SHALL have port illegal_code  output  1  one-cycle pulse: last sample was not a Johnson code.
REQ-011 SHALL have port seq_error  output  1  one-cycle pulse: loss of lock.
REQ-012 SHALL have port locked  output  1  level: FSM in LOCKED.
REQ-013 SHALL have port err_count  output  8  saturating count of seq_error pulses.

Function
REQ-014 SHALL decode a code of k leading ones followed by zeros (k=0..WIDTH) to index k, e.g. 0000->0, 1100->2, 1111->4.
REQ-015 SHALL decode a code of j>=1 leading zeros followed by ones to index WIDTH+j, e.g. 0111->5, 0001->7.
REQ-016 SHALL treat every other code as illegal, e.g. 0100, 1010.
REQ-017 SHALL register all outputs; a sample with code_valid=1 at edge N is reflected in the outputs after edge N+1 (latency 1).
REQ-018 SHALL, on a legal sample, update state_idx and pulse idx_valid; on an illegal sample, hold state_idx and pulse illegal_code.
REQ-019 SHALL define a step as good when the sample is legal and its index = (previous index + 1) mod 2*WIDTH, with 7->0 as the wrap for WIDTH=4.
REQ-020 SHALL treat a legal sample with load_seen=1 as good and as the new reference, whatever its index.
REQ-021 SHALL give illegal_code priority over load_seen when both occur together.
REQ-022 SHALL ignore load_seen and code_in while code_valid=0; all state holds.
REQ-023 SHALL have FSM state SEARCH: a good step increments the match count; a bad step or illegal sample clears it; reaching LOCK_CNT moves to LOCKED.
REQ-024 SHALL treat the first legal sample after reset as the reference with match count 0, not as a step.
REQ-025 SHALL have FSM state LOCKED: a good step stays in LOCKED; a bad step or illegal sample moves to SEARCH, pulses seq_error and clears the match count.
REQ-026 SHALL not pulse seq_error for any error while in SEARCH.
REQ-027 SHALL saturate err_count at 255, with no wrap.

Reset
REQ-028 SHALL, while clear=1, force: FSM=SEARCH, match count=0, reference invalid, state_idx=0, idx_valid=0, illegal_code=0, seq_error=0, locked=0, err_count=0.
REQ-029 SHALL, when clear is asserted mid-operation, drop locked in the same cycle (asynchronously) and restart at REQ-024.

Configuration
REQ-030 SHALL use macro JOHNSON_ERRCNT_EN; when defined, err_count behaves per REQ-013/REQ-027.
REQ-031 SHALL, when JOHNSON_ERRCNT_EN is undefined, keep the err_count port, tie it to 0 and remove the counter logic.

Structure
REQ-032 SHALL declare the FSM state enum (SEARCH, LOCKED) and the error-counter width constant in a shared package, johnson_pkg.
REQ-033 SHALL place the combinational code-to-index decode and legality check in sub-module johnson_decode, parameterised by WIDTH.

Verification
REQ-034 SHALL cover: reset, then codes 0000,1000,1100,1110 with code_valid=1 -> locked=1 after the 4th sample's output edge, state_idx=3.
REQ-035 SHALL cover: locked, then 0001 followed by 0000 -> wrap is accepted, locked stays 1, state_idx=0.
REQ-036 SHALL cover: locked at idx 2, then 0100 -> illegal_code pulse, seq_error pulse, locked=0, state_idx stays 2, err_count=1.
REQ-037 SHALL cover: locked at idx 1, then 0111 with load_seen=1 -> no error, state_idx=5, locked stays 1.
REQ-038 SHALL cover: locked, then skip 1100->1111 -> seq_error pulse; three more good steps -> locked=1 again.
REQ-039 SHALL cover: 300 forced errors -> err_count=255 with the macro defined, 0 without; clear asserted mid-lock -> locked=0 immediately.
